// File: rtl/regfile_pkg.sv
// regfile_pkg: clear-engine state encoding and default register-file geometry
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential clear engine walking every register once, with busy/done handshake
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              idle
);
  clr_state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state == IDLE  ? (clr_req ? CLEAR : IDLE) :
              state == CLEAR ? (&cnt ? DONE : CLEAR) : IDLE;
    cnt_n   = state == CLEAR ? cnt + 1'b1 :
              (state == IDLE && clr_req) ? '0 : cnt;
  end
  assign clr_idx  = cnt;
  assign clr_busy = state == CLEAR;
  assign clr_done = state == DONE;
  assign idle     = state == IDLE;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised 2R1W register file with bypass, pending scoreboard and clear engine
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_a,
  output logic              pend_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [ADDR_W-1:0] clr_idx;
  logic              idle, wr_ok, res_ok;
  regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk, .rst, .clr_req, .clr_idx, .clr_busy, .clr_done, .idle
  );
  assign wr_ok  = idle && wr_en && !(ZERO_REG && wr_addr == '0);
  assign res_ok = idle && res_en && !(ZERO_REG && res_addr == '0);
  // a reservation in the same cycle as a write wins: it names a newer producer
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else if (clr_busy) begin
      mem[clr_idx]  <= '0;
      pend[clr_idx] <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr]  <= wr_data;
        pend[wr_addr] <= 1'b0;
      end
      if (res_ok) pend[res_addr] <= 1'b1;
    end
  assign rd_data_a = (ZERO_REG && rd_addr_a == '0) ? '0 :
                     (BYPASS && wr_ok && wr_addr == rd_addr_a) ? wr_data : mem[rd_addr_a];
  assign rd_data_b = (ZERO_REG && rd_addr_b == '0) ? '0 :
                     (BYPASS && wr_ok && wr_addr == rd_addr_b) ? wr_data : mem[rd_addr_b];
  assign pend_a = pend[rd_addr_a];
  assign pend_b = pend[rd_addr_b];
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: vector table plus clear/reset sequences for two regfile_param configurations
module tb_regfile_param;
  logic clk = 0, rst = 1;
  logic [2:0] ra = 0, rb = 0, wr_addr = 0, res_addr = 0;
  logic [7:0] wr_data = 0;
  logic wr_en = 0, res_en = 0, clr_req = 0;
  logic [7:0] rd_data_a, rd_data_b, z_rd_data_a, z_rd_data_b;
  logic pend_a, pend_b, clr_busy, clr_done, z_pend_a, z_pend_b, z_clr_busy, z_clr_done;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  regfile_param dut (
    .clk(clk), .rst(rst), .rd_addr_a(ra), .rd_data_a(rd_data_a), .rd_addr_b(rb), .rd_data_b(rd_data_b),
    .pend_a(pend_a), .pend_b(pend_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .res_en(res_en), .res_addr(res_addr), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );
  regfile_param #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_z (
    .clk(clk), .rst(rst), .rd_addr_a(ra), .rd_data_a(z_rd_data_a), .rd_addr_b(rb), .rd_data_b(z_rd_data_b),
    .pend_a(z_pend_a), .pend_b(z_pend_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .res_en(res_en), .res_addr(res_addr), .clr_req(clr_req), .clr_busy(z_clr_busy), .clr_done(z_clr_done)
  );
  typedef struct {
    logic we; logic [2:0] wa; logic [7:0] wd; logic re; logic [2:0] rsa; logic [2:0] a, b;
    logic [7:0] ea, eb; logic epa, epb; logic [7:0] za; logic zpa;
  } vec_t;
  typedef struct { logic [7:0] ea, eb; logic epa, epb; logic [7:0] za; logic zpa; } exp_t;
  vec_t vecs[13];
  exp_t sb[$];
  exp_t e;
  int busy_n, done_n, bad;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i); #1;
      chk($sformatf("%s a%0d", tag, i), rd_data_a, 8'h00);
      chk($sformatf("%s b%0d", tag, i), rd_data_b, 8'h00);
      chk($sformatf("%s pa%0d", tag, i), {7'd0, pend_a}, 8'h00);
      chk($sformatf("%s pb%0d", tag, i), {7'd0, pend_b}, 8'h00);
      chk($sformatf("%s za%0d", tag, i), z_rd_data_b, 8'h00);
      chk($sformatf("%s zpb%0d", tag, i), {7'd0, z_pend_b}, 8'h00);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    //          we wa   wd   re rsa  a    b    ea     eb     pa pb  za     zpa
    vecs[0]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd5, 8'h00, 8'h00, 0, 0, 8'h00, 0};
    vecs[1]  = '{1, 3'd3, 8'hA5, 0, 3'd0, 3'd3, 3'd0, 8'hA5, 8'h00, 0, 0, 8'h00, 0};
    vecs[2]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd3, 8'hA5, 8'hA5, 0, 0, 8'hA5, 0};
    vecs[3]  = '{1, 3'd5, 8'h3C, 0, 3'd0, 3'd5, 3'd5, 8'h3C, 8'h3C, 0, 0, 8'h00, 0};
    vecs[4]  = '{0, 3'd0, 8'h00, 1, 3'd2, 3'd5, 3'd2, 8'h3C, 8'h00, 0, 0, 8'h3C, 0};
    vecs[5]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd2, 8'hA5, 8'h00, 0, 1, 8'hA5, 0};
    vecs[6]  = '{1, 3'd2, 8'h11, 0, 3'd0, 3'd3, 3'd2, 8'hA5, 8'h11, 0, 1, 8'hA5, 0};
    vecs[7]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd2, 8'hA5, 8'h11, 0, 0, 8'hA5, 0};
    vecs[8]  = '{1, 3'd4, 8'h77, 1, 3'd4, 3'd4, 3'd4, 8'h77, 8'h77, 0, 0, 8'h00, 0};
    vecs[9]  = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd4, 3'd4, 8'h77, 8'h77, 1, 1, 8'h77, 1};
    vecs[10] = '{1, 3'd0, 8'hFF, 1, 3'd0, 3'd0, 3'd3, 8'hFF, 8'hA5, 0, 0, 8'h00, 0};
    vecs[11] = '{0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd4, 8'hFF, 8'h77, 1, 1, 8'h00, 0};
    vecs[12] = '{1, 3'd0, 8'hFF, 0, 3'd0, 3'd0, 3'd0, 8'hFF, 8'hFF, 1, 1, 8'h00, 0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst busy", {7'd0, clr_busy}, 8'h00);
    chk("rst done", {7'd0, clr_done}, 8'h00);
    chk("rst z busy", {7'd0, z_clr_busy}, 8'h00);
    chk("rst z done", {7'd0, z_clr_done}, 8'h00);
    chk_all_zero("rst");
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      res_en = vecs[i].re; res_addr = vecs[i].rsa; ra = vecs[i].a; rb = vecs[i].b;
      sb.push_back('{vecs[i].ea, vecs[i].eb, vecs[i].epa, vecs[i].epb, vecs[i].za, vecs[i].zpa});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d a", i), rd_data_a, e.ea);
      chk($sformatf("v%0d b", i), rd_data_b, e.eb);
      chk($sformatf("v%0d pa", i), {7'd0, pend_a}, {7'd0, e.epa});
      chk($sformatf("v%0d pb", i), {7'd0, pend_b}, {7'd0, e.epb});
      chk($sformatf("v%0d za", i), z_rd_data_a, e.za);
      chk($sformatf("v%0d zpa", i), {7'd0, z_pend_a}, {7'd0, e.zpa});
    end
    // fill and reserve every register, then clear while a write is being attempted
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      wr_en = 1; wr_addr = 3'(i); wr_data = 8'(8'h11 * (i + 1)); res_en = 1; res_addr = 3'(i);
    end
    @(posedge clk); #1;
    wr_en = 0; res_en = 0; clr_req = 1; ra = 7; rb = 5; #1;
    chk("fill a7", rd_data_a, 8'h88);
    chk("fill pa7", {7'd0, pend_a}, 8'h01);
    @(posedge clk); #1;
    clr_req = 0; wr_en = 1; wr_addr = 7; wr_data = 8'hEE;
    busy_n = 0; done_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (clr_busy) begin
        if (busy_n == 2) begin
          chk("clr mid a7", rd_data_a, 8'h88);
          chk("clr mid b5", rd_data_b, 8'h66);
        end
        busy_n++;
      end
      if (clr_done) begin
        done_n++;
        wr_en = 0;
      end
      if (!clr_busy && !clr_done && busy_n > 0) break;
    end
    chk("clr busy cycles", 8'(busy_n), 8'd8);
    chk("clr done pulses", 8'(done_n), 8'd1);
    wr_en = 0;
    chk_all_zero("clr");
    // reset in the third busy cycle aborts the clear without a done pulse
    @(posedge clk); #1;
    wr_en = 1; wr_addr = 6; wr_data = 8'h5A;
    @(posedge clk); #1;
    wr_en = 0; ra = 6; clr_req = 1; #1;
    chk("rc pre a6", rd_data_a, 8'h5A);
    @(posedge clk); #1;
    clr_req = 0;
    repeat (3) @(negedge clk);
    chk("rc busy", {7'd0, clr_busy}, 8'h01);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rc busy after", {7'd0, clr_busy}, 8'h00);
    chk("rc done after", {7'd0, clr_done}, 8'h00);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (clr_busy || clr_done) bad++;
    end
    chk("rc quiet", 8'(bad), 8'd0);
    chk_all_zero("rc");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 8x8 datapath register file.
- Provides DEPTH registers of DATA_W bits, with two combinational read ports, one write port and optional write-to-read bypass.
- Adds a per-register pending scoreboard for hazard detection and a sequential clear engine with a busy/done handshake.
- Sits between decode (addresses, reservations) and writeback (write data).

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W.
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes/reservations.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data.
- pend_a  out  1  register at rd_addr_a has an outstanding producer.
- pend_b  out  1  register at rd_addr_b has an outstanding producer.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- res_en  in  1  reserve (mark pending) register res_addr.
- res_addr  in  ADDR_W  reservation address.
- clr_req  in  1  request full-file clear.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset (rst=1 at an edge): all registers <= 0, all pend bits <= 0, FSM <= IDLE, counter <= 0. Takes priority over everything, including an in-progress clear.
- After reset: rd_data_* = 0, pend_* = 0, clr_busy = 0, clr_done = 0.
- Reads: combinational, zero latency; rd_data_x = reg[rd_addr_x].
- Bypass (BYPASS=1, FSM=IDLE): if wr_en and wr_addr==rd_addr_x, then rd_data_x = wr_data.
- Zero register (ZERO_REG=1): address 0 always reads 0, never bypassed, never written, never pending.
- Write: if wr_en in IDLE, reg[wr_addr] <= wr_data at the edge and pend[wr_addr] <= 0. Both ports may read the same address.
- Reservation: if res_en in IDLE, pend[res_addr] <= 1.
  - Same cycle, same address as a write: reservation wins (pend=1, data still written), since a newer producer exists.
- pend_x = pend[rd_addr_x]; combinational, not bypassed (reflects registered state).
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, counter <= 0. A write/reservation in that same cycle is still performed.
  - CLEAR: reg[counter] <= 0 and pend[counter] <= 0 each cycle; counter increments. When counter==DEPTH-1 -> DONE. The counter wraps naturally; no overflow state.
  - DONE: clr_done=1 for exactly one cycle, then -> IDLE.
- clr_busy = 1 in CLEAR only. A clear takes DEPTH cycles busy, then one done cycle.
- In CLEAR and DONE:
  - wr_en and res_en are ignored (dropped, not queued).
  - clr_req is ignored.
  - Bypass is disabled.
  - Reads return current storage: already-cleared entries read 0, others read their old value.
- clr_req held high across DONE does not retrigger until FSM is IDLE. If still high in IDLE, a new clear starts.

Decomposition:
- Shared package regfile_pkg holds the FSM state enum (IDLE, CLEAR, DONE) and default DATA_W/ADDR_W constants used by the CPU top.
- One natural sub-module: regfile_clr_fsm (state register, counter, clr_busy/clr_done, write-block signal).
- Storage, bypass and scoreboard stay in regfile_param.

Test Plan:
- Reset then read all addresses -> every rd_data=0, pend=0; write reg3=0xA5, read A=3 next cycle -> 0xA5.
- Same-cycle write reg5=0x3C with rd_addr_a=5: BYPASS=1 -> rd_data_a=0x3C that cycle; BYPASS=0 -> old value (0x00).
- ZERO_REG=1: write reg0=0xFF and res_en on reg0 -> rd_data_a(addr0)=0, pend_a=0 on all following cycles.
- Reserve reg2 -> pend_b(addr2)=1 next cycle; write reg2=0x11 -> pend clears. Reserve and write reg4 in the same cycle -> reg4=data, pend stays 1.
- Fill all regs, pulse clr_req -> clr_busy high exactly 8 cycles (DEPTH=8), clr_done one pulse, all regs 0; wr_en during busy has no effect.
- Assert rst during CLEAR cycle 3 -> next cycle FSM IDLE, clr_busy=0, clr_done never pulses, all regs 0.
